// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, operator codes and key classification for calc_sequencer
package calc_pkg;

    localparam int OPW_DEF = 2;

    localparam logic [OPW_DEF-1:0] OP_ADD = 2'd0;
    localparam logic [OPW_DEF-1:0] OP_SUB = 2'd1;
    localparam logic [OPW_DEF-1:0] OP_MUL = 2'd2;
    localparam logic [OPW_DEF-1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP1  = 3'd1,
        ST_OP2  = 3'd2,
        ST_WAIT = 3'd3,
        ST_SHOW = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_DIGIT = 3'd1,
        KEY_OP    = 3'd2,
        KEY_EQ    = 3'd3,
        KEY_CLR   = 3'd4
    } key_t;

    // Collapse the class flags to one key kind: clr > eq > op > digit.
    function automatic key_t classify_key(input logic valid, input logic is_digit,
                                          input logic is_op, input logic is_eq,
                                          input logic is_clr);
        key_t k;
        k = KEY_NONE;
        if (valid) begin
            if (is_clr)        k = KEY_CLR;
            else if (is_eq)    k = KEY_EQ;
            else if (is_op)    k = KEY_OP;
            else if (is_digit) k = KEY_DIGIT;
        end
        return k;
    endfunction

endpackage

// File: rtl/calc_digit_counter.sv
// rtl/calc_digit_counter.sv - saturating 0..DIGITS digit counter with clear/load-1/increment
module calc_digit_counter #(
    parameter int DIGITS = 4,
    localparam int CNTW  = $clog2(DIGITS + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_clear,
    input  logic            i_load1,
    input  logic            i_inc,
    output logic [CNTW-1:0] o_cnt,
    output logic            o_full
);

    logic [CNTW-1:0] r_cnt;
    logic            w_full;

    assign w_full = (r_cnt == CNTW'(DIGITS));

    // Clear beats load-1 beats increment; increment stops at DIGITS.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= CNTW'(1);
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_full = w_full;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad-driven control sequencer for the calculator datapath
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OPW    = OPW_DEF,
    localparam int CNTW  = $clog2(DIGITS + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_key_valid,
    input  logic            i_key_is_digit,
    input  logic            i_key_is_op,
    input  logic            i_key_is_eq,
    input  logic            i_key_is_clr,
    input  logic [OPW-1:0]  i_key_op,
    input  logic            i_alu_done,
    input  logic            i_alu_err,
    output logic            o_op1_shift,
    output logic            o_op2_shift,
    output logic            o_op1_clear,
    output logic            o_op2_clear,
    output logic            o_acc_to_op1,
    output logic            o_calc_start,
    output logic [OPW-1:0]  o_op_code,
    output logic [CNTW-1:0] o_digit_cnt,
    output logic            o_show_result,
    output logic            o_error,
    output logic            o_busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    key_t            w_key;

    logic [OPW-1:0]  r_op_code;
    logic [OPW-1:0]  r_pending;
    logic            r_chain;
    logic            r_op1_shift;
    logic            r_op2_shift;
    logic            r_op1_clear;
    logic            r_op2_clear;
    logic            r_acc_to_op1;
    logic            r_calc_start;
    logic            r_show_result;
    logic            r_error;
    logic            r_busy;

    logic [OPW-1:0]  w_op_code_nxt;
    logic [OPW-1:0]  w_pending_nxt;
    logic            w_chain_nxt;
    logic            w_op1_shift_nxt;
    logic            w_op2_shift_nxt;
    logic            w_op1_clear_nxt;
    logic            w_op2_clear_nxt;
    logic            w_acc_to_op1_nxt;
    logic            w_calc_start_nxt;
    logic            w_cnt_clear;
    logic            w_cnt_load1;
    logic            w_cnt_inc;
    logic [CNTW-1:0] w_cnt;
    logic            w_cnt_full;
    logic            w_cnt_zero;

    assign w_key      = classify_key(i_key_valid, i_key_is_digit, i_key_is_op,
                                     i_key_is_eq, i_key_is_clr);
    assign w_cnt_zero = (w_cnt == '0);

    calc_digit_counter #(
        .DIGITS (DIGITS)
    ) u_digit_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_cnt_clear),
        .i_load1 (w_cnt_load1),
        .i_inc   (w_cnt_inc),
        .o_cnt   (w_cnt),
        .o_full  (w_cnt_full)
    );

    // State register plus the registered output stage, all loaded on the same edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_op_code     <= '0;
            r_pending     <= '0;
            r_chain       <= 1'b0;
            r_op1_shift   <= 1'b0;
            r_op2_shift   <= 1'b0;
            r_op1_clear   <= 1'b0;
            r_op2_clear   <= 1'b0;
            r_acc_to_op1  <= 1'b0;
            r_calc_start  <= 1'b0;
            r_show_result <= 1'b0;
            r_error       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_op_code     <= w_op_code_nxt;
            r_pending     <= w_pending_nxt;
            r_chain       <= w_chain_nxt;
            r_op1_shift   <= w_op1_shift_nxt;
            r_op2_shift   <= w_op2_shift_nxt;
            r_op1_clear   <= w_op1_clear_nxt;
            r_op2_clear   <= w_op2_clear_nxt;
            r_acc_to_op1  <= w_acc_to_op1_nxt;
            r_calc_start  <= w_calc_start_nxt;
            r_show_result <= (w_state_nxt == ST_SHOW);
            r_error       <= (w_state_nxt == ST_ERR);
            r_busy        <= (w_state_nxt == ST_WAIT);
        end
    end

    // Next-state decision; clear overrides everything, including a coincident alu_done.
    always_comb begin
        w_state_nxt = r_state;
        if (w_key == KEY_CLR) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_key == KEY_DIGIT) w_state_nxt = ST_OP1;
                ST_OP1:  if (w_key == KEY_OP)    w_state_nxt = ST_OP2;
                ST_OP2: begin
                    if (!w_cnt_zero && (w_key == KEY_EQ || w_key == KEY_OP))
                        w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_alu_done) begin
                        if (i_alu_err)    w_state_nxt = ST_ERR;
                        else if (r_chain) w_state_nxt = ST_OP2;
                        else              w_state_nxt = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (w_key == KEY_DIGIT)   w_state_nxt = ST_OP1;
                    else if (w_key == KEY_OP) w_state_nxt = ST_OP2;
                end
                ST_ERR:  w_state_nxt = ST_ERR;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next values of pulses, operator/pending/chain and digit-counter controls.
    always_comb begin
        w_op_code_nxt    = r_op_code;
        w_pending_nxt    = r_pending;
        w_chain_nxt      = r_chain;
        w_op1_shift_nxt  = 1'b0;
        w_op2_shift_nxt  = 1'b0;
        w_op1_clear_nxt  = 1'b0;
        w_op2_clear_nxt  = 1'b0;
        w_acc_to_op1_nxt = 1'b0;
        w_calc_start_nxt = 1'b0;
        w_cnt_clear      = 1'b0;
        w_cnt_load1      = 1'b0;
        w_cnt_inc        = 1'b0;
        if (w_key == KEY_CLR) begin
            // Clear also drops the operator so the block looks freshly reset.
            w_op1_clear_nxt = 1'b1;
            w_op2_clear_nxt = 1'b1;
            w_cnt_clear     = 1'b1;
            w_chain_nxt     = 1'b0;
            w_pending_nxt   = '0;
            w_op_code_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_SHOW: begin
                    if (w_key == KEY_DIGIT) begin
                        w_op1_clear_nxt = 1'b1;
                        w_op1_shift_nxt = 1'b1;
                        w_cnt_load1     = 1'b1;
                    end else if (w_key == KEY_OP && r_state == ST_SHOW) begin
                        w_acc_to_op1_nxt = 1'b1;
                        w_op_code_nxt    = i_key_op;
                        w_op2_clear_nxt  = 1'b1;
                        w_cnt_clear      = 1'b1;
                    end
                end
                ST_OP1: begin
                    if (w_key == KEY_DIGIT && !w_cnt_full) begin
                        w_op1_shift_nxt = 1'b1;
                        w_cnt_inc       = 1'b1;
                    end else if (w_key == KEY_OP) begin
                        w_op_code_nxt   = i_key_op;
                        w_op2_clear_nxt = 1'b1;
                        w_cnt_clear     = 1'b1;
                    end
                end
                ST_OP2: begin
                    if (w_cnt_zero) begin
                        // No second-operand digit yet: an operator only replaces the pending one.
                        if (w_key == KEY_DIGIT) begin
                            w_op2_clear_nxt = 1'b1;
                            w_op2_shift_nxt = 1'b1;
                            w_cnt_load1     = 1'b1;
                        end else if (w_key == KEY_OP) begin
                            w_op_code_nxt = i_key_op;
                        end
                    end else begin
                        if (w_key == KEY_DIGIT && !w_cnt_full) begin
                            w_op2_shift_nxt = 1'b1;
                            w_cnt_inc       = 1'b1;
                        end else if (w_key == KEY_EQ) begin
                            w_calc_start_nxt = 1'b1;
                            w_chain_nxt      = 1'b0;
                        end else if (w_key == KEY_OP) begin
                            w_calc_start_nxt = 1'b1;
                            w_pending_nxt    = i_key_op;
                            w_chain_nxt      = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_alu_done && !i_alu_err && r_chain) begin
                        w_acc_to_op1_nxt = 1'b1;
                        w_op_code_nxt    = r_pending;
                        w_op2_clear_nxt  = 1'b1;
                        w_cnt_clear      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_op1_shift   = r_op1_shift;
    assign o_op2_shift   = r_op2_shift;
    assign o_op1_clear   = r_op1_clear;
    assign o_op2_clear   = r_op2_clear;
    assign o_acc_to_op1  = r_acc_to_op1;
    assign o_calc_start  = r_calc_start;
    assign o_op_code     = r_op_code;
    assign o_digit_cnt   = w_cnt;
    assign o_show_result = r_show_result;
    assign o_error       = r_error;
    assign o_busy        = r_busy;

endmodule
